// File: rtl/noc_pkg.sv
// Shared NoC router types and constants.
// Used by the crossbar input-side steering logic.
package noc_pkg;
  localparam int PORT_N = 5;
  localparam int DATA_W = 32;
  localparam int VCH_N  = 2;
  localparam int VCH_W  = 2;
  localparam int VCH_IW = (VCH_N > 1) ? $clog2(VCH_N) : 1;

  localparam logic [1:0] FLIT_TYPE_BODY     = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEAD     = 2'b01;
  localparam logic [1:0] FLIT_TYPE_TAIL     = 2'b10;
  localparam logic [1:0] FLIT_TYPE_HEADTAIL = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [VCH_W-1:0]  vch;
    logic [DATA_W-1:0] data;
  } router_i_t;

  typedef enum logic {
    VC_IDLE,
    VC_ACTIVE
  } vc_state_t;

  function automatic logic is_onehot(input logic [PORT_N-1:0] x);
    return (x != '0) && ((x & (x - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/vc_route_reg.sv
// Per-virtual-channel wormhole state: packet-open flag and latched route.
// Only sees flits the top level has already accepted for this VC.
module vc_route_reg
  import noc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flit_valid,
  input  logic [1:0]        flit_type,
  input  logic [PORT_N-1:0] route,
  output logic [PORT_N-1:0] route_q,
  output logic              busy
);
  vc_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= VC_IDLE;
      route_q <= '0;
    end else if (flit_valid) begin
      case (flit_type)
        FLIT_TYPE_HEAD: begin
          state   <= VC_ACTIVE;
          route_q <= route;
        end
        FLIT_TYPE_HEADTAIL,
        FLIT_TYPE_TAIL: state <= VC_IDLE;
        default: ;
      endcase
    end
  end

  assign busy = (state == VC_ACTIVE);
endmodule

// File: rtl/xbar_demux.sv
// Crossbar input-side demux: steers each flit to one output lane,
// holding the head's route per VC until the tail closes the packet.
module xbar_demux
  import noc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  router_i_t                    demux_i,
  input  logic [PORT_N-1:0]            route_i,
  output router_i_t [PORT_N-1:0]       demux_o,
  output logic [PORT_N-1:0]            sel_o,
  output logic [VCH_N-1:0]             busy_o,
  output logic                         err_o
);
  logic [1:0]        ftype;
  logic [VCH_IW-1:0] vidx;
  logic              vch_ok;
  logic              is_head;
  logic              accept;
  logic              err;
  logic [PORT_N-1:0] sel;
  logic [VCH_N-1:0]  busy;
  logic [PORT_N-1:0] route_q [VCH_N];

  assign ftype   = demux_i.data[DATA_W-1:DATA_W-2];
  assign vidx    = demux_i.vch[VCH_IW-1:0];
  assign vch_ok  = demux_i.vch < VCH_W'(VCH_N);
  assign is_head = ftype == FLIT_TYPE_HEAD ||
                   ftype == FLIT_TYPE_HEADTAIL;

  always_comb begin
    sel    = '0;
    err    = 1'b0;
    accept = 1'b0;
    if (demux_i.valid) begin
      priority case (1'b1)
        !vch_ok: err = 1'b1;
        is_head && !is_onehot(route_i): err = 1'b1;
        is_head: begin
          sel    = route_i;
          accept = 1'b1;
          // A head on an open packet means its tail was lost.
          err    = ftype == FLIT_TYPE_HEAD && busy[vidx];
        end
        busy[vidx]: begin
          sel    = route_q[vidx];
          accept = 1'b1;
        end
        default: err = 1'b1;
      endcase
    end
  end

  for (genvar v = 0; v < VCH_N; v++) begin : g_vc
    vc_route_reg u_vc (
      .clk        (clk),
      .rst        (rst),
      .flit_valid (accept && vidx == VCH_IW'(v)),
      .flit_type  (ftype),
      .route      (route_i),
      .route_q    (route_q[v]),
      .busy       (busy[v])
    );
  end

  assign busy_o = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      demux_o <= '0;
      sel_o   <= '0;
      err_o   <= 1'b0;
    end else begin
      for (int i = 0; i < PORT_N; i++)
        demux_o[i] <= sel[i] ? demux_i : '0;
      sel_o <= sel;
      err_o <= err;
    end
  end
endmodule

// File: tb/tb_xbar_demux.sv
// Self-checking bench for xbar_demux: directed packet scenarios
// plus randomized traffic against a packet-level reference model.
module tb_xbar_demux;
  import noc_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  router_i_t              demux_i;
  logic [PORT_N-1:0]      route_i;
  router_i_t [PORT_N-1:0] demux_o;
  logic [PORT_N-1:0]      sel_o;
  logic [VCH_N-1:0]       busy_o;
  logic                   err_o;

  xbar_demux dut (
    .clk     (clk),
    .rst     (rst),
    .demux_i (demux_i),
    .route_i (route_i),
    .demux_o (demux_o),
    .sel_o   (sel_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  bit                     m_act [VCH_N];
  logic [PORT_N-1:0]      m_rt  [VCH_N];
  router_i_t [PORT_N-1:0] exp_demux;
  logic [PORT_N-1:0]      exp_sel;
  logic [VCH_N-1:0]       exp_busy;
  logic                   exp_err;

  function automatic router_i_t mk(input bit vld, input int vc,
                                   input logic [1:0] t);
    router_i_t f;
    f.valid = vld;
    f.vch   = VCH_W'(vc);
    f.data  = {t, 30'($urandom)};
    return f;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VCH_N; v++) begin
      m_act[v] = 0;
      m_rt[v]  = '0;
    end
  endtask

  // Packet-level reference: which lane, if any, this flit lands on.
  task automatic model(input router_i_t f, input logic [PORT_N-1:0] r);
    int v;
    logic [1:0] t;
    exp_sel = '0;
    exp_err = 1'b0;
    v = int'(f.vch);
    t = f.data[DATA_W-1:DATA_W-2];
    if (f.valid) begin
      if (v >= VCH_N) exp_err = 1'b1;
      else if (t == FLIT_TYPE_HEAD || t == FLIT_TYPE_HEADTAIL) begin
        if ($countones(r) != 1) exp_err = 1'b1;
        else begin
          exp_sel = r;
          if (t == FLIT_TYPE_HEAD) begin
            exp_err = m_act[v];
            m_act[v] = 1;
            m_rt[v] = r;
          end else m_act[v] = 0;
        end
      end else if (!m_act[v]) exp_err = 1'b1;
      else begin
        exp_sel = m_rt[v];
        if (t == FLIT_TYPE_TAIL) m_act[v] = 0;
      end
    end
    for (int i = 0; i < PORT_N; i++)
      exp_demux[i] = exp_sel[i] ? f : '0;
    for (int i = 0; i < VCH_N; i++)
      exp_busy[i] = m_act[i];
  endtask

  // Drive one flit at the falling edge, observe 1 ns after the rising edge.
  task automatic apply(input router_i_t f, input logic [PORT_N-1:0] r);
    @(negedge clk);
    demux_i = f;
    route_i = r;
    model(f, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    demux_i = '0;
    route_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({demux_o, sel_o, err_o, busy_o} !== '0)
      $display("FAIL reset: got demux=%h sel=%b err=%b busy=%b want all 0",
               demux_o, sel_o, err_o, busy_o);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wormhole();
    logic [1:0] ty [4] = '{FLIT_TYPE_HEAD, FLIT_TYPE_BODY,
                           FLIT_TYPE_BODY, FLIT_TYPE_TAIL};
    logic [VCH_N-1:0] bz [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
    router_i_t f;
    for (int k = 0; k < 4; k++) begin
      f = mk(1, 0, ty[k]);
      apply(f, 5'b00100);
      checks++;
      if (demux_o[2] !== f || sel_o !== 5'b00100 || err_o !== 1'b0 ||
          busy_o !== bz[k] || demux_o[1:0] !== '0 || demux_o[4:3] !== '0)
        $display("FAIL wormhole[%0d]: got lane2=%h sel=%b err=%b busy=%b want lane2=%h sel=00100 err=0 busy=%b",
                 k, demux_o[2], sel_o, err_o, busy_o, f, bz[k]);
      else passes++;
    end
    apply('0, '0);
    checks++;
    if (demux_o !== '0 || sel_o !== '0 || busy_o !== 2'b00)
      $display("FAIL wormhole_idle: got sel=%b busy=%b want 0 0", sel_o, busy_o);
    else passes++;
  endtask

  task automatic test_headtail();
    router_i_t f;
    f = mk(1, 1, FLIT_TYPE_HEADTAIL);
    apply(f, 5'b00001);
    checks++;
    if (demux_o[0] !== f || sel_o !== 5'b00001 || busy_o !== 2'b00 ||
        err_o !== 1'b0)
      $display("FAIL headtail: got lane0=%h sel=%b busy=%b err=%b want lane0=%h sel=00001 busy=00 err=0",
               demux_o[0], sel_o, busy_o, err_o, f);
    else passes++;
  endtask

  task automatic test_interleave();
    int               vc [5] = '{0, 1, 0, 1, 0};
    logic [1:0]       ty [5] = '{FLIT_TYPE_HEAD, FLIT_TYPE_HEAD,
                                 FLIT_TYPE_BODY, FLIT_TYPE_TAIL,
                                 FLIT_TYPE_TAIL};
    logic [PORT_N-1:0] rt [5] = '{5'b01000, 5'b00010, 5'b00111,
                                  5'b00000, 5'b11111};
    router_i_t f;
    int lane;
    for (int k = 0; k < 5; k++) begin
      f = mk(1, vc[k], ty[k]);
      apply(f, rt[k]);
      lane = vc[k] == 0 ? 3 : 1;
      checks++;
      if (demux_o[lane] !== f || err_o !== 1'b0 ||
          {demux_o, sel_o, err_o, busy_o} !==
          {exp_demux, exp_sel, exp_err, exp_busy})
        $display("FAIL interleave[%0d]: got sel=%b err=%b busy=%b want lane %0d err=0 busy=%b",
                 k, sel_o, err_o, busy_o, lane, exp_busy);
      else passes++;
    end
  endtask

  task automatic test_bad_route();
    apply(mk(1, 0, FLIT_TYPE_HEAD), 5'b00110);
    checks++;
    if (err_o !== 1'b1 || demux_o !== '0 || sel_o !== '0 || busy_o !== '0)
      $display("FAIL bad_route: got err=%b sel=%b busy=%b want err=1 sel=0 busy=0",
               err_o, sel_o, busy_o);
    else passes++;
    apply(mk(1, 0, FLIT_TYPE_BODY), 5'b00001);
    checks++;
    if (err_o !== 1'b1 || demux_o !== '0 || sel_o !== '0)
      $display("FAIL orphan_body: got err=%b sel=%b want err=1 sel=0",
               err_o, sel_o);
    else passes++;
    apply(mk(1, 2, FLIT_TYPE_HEADTAIL), 5'b00001);
    checks++;
    if (err_o !== 1'b1 || sel_o !== '0)
      $display("FAIL bad_vch: got err=%b sel=%b want err=1 sel=0",
               err_o, sel_o);
    else passes++;
  endtask

  task automatic test_reset_mid();
    apply(mk(1, 0, FLIT_TYPE_HEAD), 5'b10000);
    @(negedge clk);
    demux_i = mk(1, 0, FLIT_TYPE_BODY);
    rst = 1'b1;
    #1;
    checks++;
    if ({demux_o, sel_o, err_o, busy_o} !== '0)
      $display("FAIL reset_mid: got sel=%b err=%b busy=%b want 0",
               sel_o, err_o, busy_o);
    else passes++;
    @(posedge clk);
    #1;
    checks++;
    if ({demux_o, sel_o, err_o, busy_o} !== '0)
      $display("FAIL reset_hold: got sel=%b err=%b busy=%b want 0",
               sel_o, err_o, busy_o);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply(mk(1, 0, FLIT_TYPE_BODY), 5'b00000);
    checks++;
    if (err_o !== 1'b1 || sel_o !== '0 || demux_o !== '0)
      $display("FAIL post_reset_body: got err=%b sel=%b want err=1 sel=0",
               err_o, sel_o);
    else passes++;
  endtask

  task automatic test_head_overwrite();
    router_i_t f;
    apply(mk(1, 0, FLIT_TYPE_HEAD), 5'b00001);
    f = mk(1, 0, FLIT_TYPE_HEAD);
    apply(f, 5'b00010);
    checks++;
    if (err_o !== 1'b1 || demux_o[1] !== f || sel_o !== 5'b00010 ||
        busy_o[0] !== 1'b1)
      $display("FAIL head_overwrite: got err=%b sel=%b busy=%b want err=1 sel=00010 busy0=1",
               err_o, sel_o, busy_o);
    else passes++;
    f = mk(1, 0, FLIT_TYPE_BODY);
    apply(f, 5'b00001);
    checks++;
    if (err_o !== 1'b0 || demux_o[1] !== f || sel_o !== 5'b00010)
      $display("FAIL overwrite_body: got err=%b sel=%b want err=0 sel=00010",
               err_o, sel_o);
    else passes++;
    apply(mk(1, 0, FLIT_TYPE_TAIL), 5'b00000);
  endtask

  task automatic test_random();
    router_i_t f;
    logic [PORT_N-1:0] r;
    int bad = 0;
    for (int k = 0; k < 400; k++) begin
      f = mk($urandom_range(0, 3) != 0,
             $urandom_range(0, 9) == 0 ? 2 : $urandom_range(0, 1),
             2'($urandom));
      r = $urandom_range(0, 7) == 0 ? PORT_N'($urandom)
                                    : PORT_N'(1) << $urandom_range(0, 4);
      apply(f, r);
      checks++;
      if ({demux_o, sel_o, err_o, busy_o} !==
          {exp_demux, exp_sel, exp_err, exp_busy}) begin
        if (bad < 10)
          $display("FAIL random[%0d]: got sel=%b err=%b busy=%b want sel=%b err=%b busy=%b",
                   k, sel_o, err_o, busy_o, exp_sel, exp_err, exp_busy);
        bad++;
      end else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_wormhole();
    test_headtail();
    test_interleave();
    test_bad_route();
    test_reset_mid();
    test_head_overwrite();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/xbar_demux.md
Name: xbar_demux

Overview:
- Crossbar input-side steering block: accepts one flit stream (valid/vch/data) from an input port and forwards each flit to exactly one of PORT_N crossbar output lanes.
- It is the counterpart of the one-hot crossbar output mux.
- Route is supplied with the head flit, latched per virtual channel, and held for body/tail flits until the tail closes the packet (wormhole).
- It sits between the input VC buffers/route computation and the crossbar output muxes. One registered stage.

Parameters:
- PORT_N, 5 (from noc_pkg), number of router ports/output lanes.
- DATA_W, 32 (from noc_pkg), flit data width including 2-bit flit-type field.
- VCH_N, 2 (from noc_pkg), number of virtual channels.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- demux_i  input  router_i_t  incoming flit {valid, vch, data}
- route_i  input  PORT_N  one-hot output port; sampled only with a valid head flit
- demux_o  output  router_i_t[PORT_N]  per-lane flit; non-selected lanes all-zero
- sel_o  output  PORT_N  registered one-hot lane of the flit on demux_o (0 if none)
- busy_o  output  VCH_N  per-VC packet-in-progress flag
- err_o  output  1  one-cycle pulse on protocol error; offending flit dropped

Behaviour:
- Flit type is data[DATA_W-1:DATA_W-2] (FLIT_TYPE_*):
  - 2'b01 HEAD
  - 2'b00 BODY
  - 2'b10 TAIL
  - 2'b11 HEADTAIL, a single-flit packet
- Per-VC state machine, indexed by demux_i.vch, with states IDLE and ACTIVE; per-VC register route_q.
- Valid HEAD/HEADTAIL with route_i exactly one-hot: sel = route_i.
  - HEAD: state goes to ACTIVE, route_q <= route_i.
  - HEADTAIL: state goes to/stays IDLE.
- Valid HEAD while ACTIVE: err_o pulses, but the flit is accepted as a new packet (route_q overwritten, stays ACTIVE). Recovers from a lost tail.
- Valid head with route_i zero or multi-hot: flit dropped, err_o pulses, VC state unchanged.
- Valid BODY in ACTIVE: sel = route_q[vch].
- Valid TAIL in ACTIVE: sel = route_q[vch], then state goes to IDLE.
- Valid BODY/TAIL in IDLE: flit dropped, err_o pulses.
- demux_i.vch >= VCH_N: flit dropped, err_o pulses.
- Output register, latency exactly 1 cycle:
  - demux_o[i] <= sel[i] ? demux_i : '0
  - sel_o <= sel
  - err_o <= error_this_cycle
- Invalid input (valid=0): all lanes zero next cycle, sel_o=0, no state change.
- No backpressure: every accepted flit appears exactly once, on exactly one lane, in input order.
- Flits of different VCs may interleave cycle-by-cycle; each VC uses its own route_q.
- busy_o[v] is the registered ACTIVE flag, updated the same edge the flit is registered. TAIL clears it on the edge that registers the tail.
- Reset (async assert, any time including mid-packet): demux_o, sel_o, err_o, busy_o, route_q all 0; all VCs IDLE. Packets in flight are abandoned; their later body/tail flits raise err_o.

Decomposition:
- noc_pkg holds:
  - PORT_N, DATA_W, VCH_N
  - router_i_t
  - FLIT_TYPE_HEAD/BODY/TAIL/HEADTAIL localparams
  - function is_onehot()
- One sub-module per VC, vc_route_reg: IDLE/ACTIVE state and route_q, with inputs flit-valid-for-this-VC, type, route_i; outputs route_q and busy. Generated VCH_N times.
- The top level does decode, the error check and the output register.

Test Plan:
- Reset, then HEAD vc0 route 5'b00100, two BODY, TAIL -> each flit appears on demux_o[2] one cycle later; other lanes 0; busy_o[0] 1 from HEAD through TAIL edge, then 0.
- HEADTAIL vc1 route 5'b00001 -> demux_o[0] carries the flit next cycle; busy_o[1] stays 0; err_o 0.
- Interleave: HEAD vc0→5'b01000, HEAD vc1→5'b00010, BODY vc0, TAIL vc1, TAIL vc0 -> vc0 flits on lane 3, vc1 flits on lane 1, order preserved.
- HEAD with route 5'b00110, then BODY with no prior head -> both dropped, err_o pulses each following cycle, all lanes 0.
- HEAD vc0 route 5'b10000, assert rst mid-packet, release, send BODY vc0 -> outputs 0 during reset; BODY dropped with err_o=1.
- HEAD vc0 route 5'b00001 followed by HEAD vc0 route 5'b00010 -> err_o pulses; second head delivered on lane 1; subsequent BODY on lane 1.
